// File: rtl/bin_to_ascii_stream.sv
// Binary-to-ASCII serializer: captures a WIDTH-bit word, streams it MSB first as '0'/'1' or hex digits.
// Optional BIN_ASCII_CRLF_EN appends CR/LF to every frame.
module bin_to_ascii_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_hex,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned IDX_W = $clog2(WIDTH + 1);
    localparam int unsigned HEX_N = (WIDTH + 3) / 4;
    localparam int unsigned PAD_W = 4 * HEX_N;

`ifdef BIN_ASCII_CRLF_EN
    typedef enum logic [1:0] {IDLE, EMIT, CR, LF} state_t;
`else
    typedef enum logic [0:0] {IDLE, EMIT} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               hex_q, hex_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_m1;
    logic               valid_d, last_d;
    logic [7:0]         char_d;
    logic [CNT_W-1:0]   cnt_d;

    // ASCII character for digit position i of word d (i counts from the LSB digit)
    function automatic logic [7:0] char_of(input logic [WIDTH-1:0] d, input logic h,
                                           input logic [IDX_W-1:0] i);
        logic [PAD_W-1:0] pad;
        logic [IDX_W+1:0] nsh;
        logic [3:0]       nib;
        logic             b;
        pad = PAD_W'(d);
        nsh = {i, 2'b00};
        nib = 4'(pad >> nsh);
        b   = |((d >> i) & WIDTH'(1));
        if (h) begin
            char_of = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h41 + 8'(nib - 4'd10));
        end else begin
            char_of = b ? 8'h31 : 8'h30;
        end
    endfunction

    // A digit carries out_last only when no CR/LF trailer follows it
    function automatic logic digit_last(input logic [IDX_W-1:0] i);
`ifdef BIN_ASCII_CRLF_EN
        digit_last = 1'b0 & (i == '0);
`else
        digit_last = (i == '0);
`endif
    endfunction

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            hex_q     <= 1'b0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            hex_q     <= hex_d;
            idx_q     <= idx_d;
            out_valid <= valid_d;
            out_char  <= char_d;
            out_last  <= last_d;
            frame_cnt <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        hex_d   = hex_q;
        idx_d   = idx_q;
        idx_m1  = idx_q - IDX_W'(1);
        valid_d = out_valid;
        char_d  = out_char;
        last_d  = out_last;
        cnt_d   = frame_cnt;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    hex_d   = in_hex;
                    idx_d   = in_hex ? IDX_W'(HEX_N - 1) : IDX_W'(WIDTH - 1);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // First beat after capture loads the MSB digit; later beats advance on transfer
                if (!out_valid) begin
                    valid_d = 1'b1;
                    char_d  = char_of(data_q, hex_q, idx_q);
                    last_d  = digit_last(idx_q);
                end else if (out_ready) begin
                    if (idx_q != '0) begin
                        idx_d  = idx_m1;
                        char_d = char_of(data_q, hex_q, idx_m1);
                        last_d = digit_last(idx_m1);
                    end else begin
`ifdef BIN_ASCII_CRLF_EN
                        state_d = CR;
                        char_d  = 8'h0D;
                        last_d  = 1'b0;
`else
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        cnt_d   = frame_cnt + CNT_W'(1);
`endif
                    end
                end
            end
`ifdef BIN_ASCII_CRLF_EN
            CR: begin
                if (out_ready) begin
                    state_d = LF;
                    char_d  = 8'h0A;
                    last_d  = 1'b1;
                end
            end
            LF: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = frame_cnt + CNT_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bin_to_ascii_stream.sv
// Bench for bin_to_ascii_stream: directed and random frames against a digit-list reference model.
module tb_bin_to_ascii_stream;

    localparam int unsigned W  = 10;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_hex;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_char;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    int         checks  = 0;
    int         errors  = 0;
    int         exp_cnt = 0;
    logic [7:0] exp_q[$];

    bin_to_ascii_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_hex(in_hex), .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected character list: digits MSB first, then optional CR/LF
    task automatic build(input logic [W-1:0] d, input logic h);
        exp_q.delete();
        if (h) begin
            for (int i = (W + 3) / 4 - 1; i >= 0; i--) begin
                int v;
                v = int'((32'(d) >> (4 * i)) % 16);
                exp_q.push_back(v < 10 ? 8'(48 + v) : 8'(65 + v - 10));
            end
        end else begin
            for (int i = W - 1; i >= 0; i--)
                exp_q.push_back(((32'(d) >> i) % 2) == 1 ? 8'h31 : 8'h30);
        end
`ifdef BIN_ASCII_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic wait_ready();
        int b;
        b = 0;
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // mode 0: out_ready always high; 1: random; 2: stall 3 cycles on the 3rd char
    task automatic run_frame(input logic [W-1:0] d, input logic h, input int mode, input logic hold);
        int   idx, cyc, stall;
        logic r, xfer;
        build(d, h);
        wait_ready();
        in_valid  = 1'b1;
        in_data   = d;
        in_hex    = h;
        out_ready = 1'b1;
        @(negedge clk);
        check("cap_busy", 32'(busy), 32'd1);
        check("cap_valid", 32'(out_valid), 32'd0);
        in_valid = hold;
        in_data  = W'($urandom);
        in_hex   = 1'($urandom);
        idx = 0; cyc = 0; stall = 0;
        while (idx < exp_q.size() && cyc < 400) begin
            if (out_valid) begin
                check("char", 32'(out_char), 32'(exp_q[idx]));
                check("last", 32'(out_last), 32'(idx == exp_q.size() - 1));
                check("busy_mid", 32'(in_ready), 32'd0);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom);
                default: begin
                    r = !(idx == 2 && out_valid && stall < 3);
                    if (!r) stall++;
                end
            endcase
            out_ready = r;
            xfer = out_valid && r;
            @(negedge clk);
            cyc++;
            if (xfer) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("frame_done", 32'(idx), 32'(exp_q.size()));
        if (mode == 0) check("frame_cycles", 32'(cyc), 32'(exp_q.size() + 1));
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("end_valid", 32'(out_valid), 32'd0);
        check("end_ready", 32'(in_ready), 32'd1);
        check("end_last", 32'(out_last), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_hex = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_char", 32'(out_char), 32'h00);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        run_frame(W'(10'h0A5), 1'b0, 0, 1'b0);
        run_frame(W'(10'h0A5), 1'b1, 0, 1'b0);
        run_frame(W'(10'h3FF), 1'b1, 0, 1'b0);
        run_frame(W'(10'h3FF), 1'b0, 0, 1'b0);
        run_frame(W'(10'h000), 1'b1, 0, 1'b0);
        run_frame(W'(10'h0A5), 1'b0, 2, 1'b1);
        run_frame(W'(10'h2C9), 1'b1, 2, 1'b1);

        // Reset while the 4th char of a frame is on the output
        wait_ready();
        in_valid = 1'b1; in_data = W'(10'h2B7); in_hex = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_char", 32'(out_char), 32'h00);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        run_frame(W'(10'h15A), 1'b1, 0, 1'b0);

        for (int n = 0; n < 24; n++)
            run_frame(W'($urandom), 1'($urandom), int'($urandom_range(0, 1)), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
